// File: rtl/lfsr_rng.sv
// Maximal-length Fibonacci LFSR random-word generator.
// Advances every clock; the state register is the output word.
module lfsr_rng #(
   parameter int          WIDTH = 16,
   parameter logic [31:0] SEED  = 32'h0000_ACE1
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] out
);

   function automatic logic [31:0] taps4(input int a, input int b, input int c, input int d);
      logic [31:0] m;
      m = '0;
      if (a > 0) m = m | (32'd1 << (a - 1));
      if (b > 0) m = m | (32'd1 << (b - 1));
      if (c > 0) m = m | (32'd1 << (c - 1));
      if (d > 0) m = m | (32'd1 << (d - 1));
      return m;
   endfunction

   // Tap n contributes bit n-1 to the feedback XOR.
   function automatic logic [31:0] tap_mask(input int w);
      case (w)
         3:       return taps4(3, 2, 0, 0);
         4:       return taps4(4, 3, 0, 0);
         5:       return taps4(5, 3, 0, 0);
         6:       return taps4(6, 5, 0, 0);
         7:       return taps4(7, 6, 0, 0);
         8:       return taps4(8, 6, 5, 4);
         9:       return taps4(9, 5, 0, 0);
         10:      return taps4(10, 7, 0, 0);
         11:      return taps4(11, 9, 0, 0);
         12:      return taps4(12, 6, 4, 1);
         13:      return taps4(13, 4, 3, 1);
         14:      return taps4(14, 5, 3, 1);
         15:      return taps4(15, 14, 0, 0);
         16:      return taps4(16, 15, 13, 4);
         17:      return taps4(17, 14, 0, 0);
         18:      return taps4(18, 11, 0, 0);
         19:      return taps4(19, 6, 2, 1);
         20:      return taps4(20, 17, 0, 0);
         21:      return taps4(21, 19, 0, 0);
         22:      return taps4(22, 21, 0, 0);
         23:      return taps4(23, 18, 0, 0);
         24:      return taps4(24, 23, 22, 17);
         25:      return taps4(25, 22, 0, 0);
         26:      return taps4(26, 6, 2, 1);
         27:      return taps4(27, 5, 2, 1);
         28:      return taps4(28, 25, 0, 0);
         29:      return taps4(29, 27, 0, 0);
         30:      return taps4(30, 6, 4, 1);
         31:      return taps4(31, 28, 0, 0);
         32:      return taps4(32, 22, 2, 1);
         default: return '0;
      endcase
   endfunction

   generate
      if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
         $error("lfsr_rng: WIDTH must be in 3..32");
      end
   endgenerate

   localparam logic [31:0]      TAPS_ALL = tap_mask(WIDTH);
   localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] RST_VAL  = (SEED[WIDTH-1:0] == '0) ? ONE : SEED[WIDTH-1:0];

   logic [WIDTH-1:0] r_state;
   logic             w_fb;
   logic [WIDTH-1:0] w_next;

   assign w_fb = ^(r_state & TAPS);
   // All-zero is the XOR lock-up state; kick it back into the sequence.
   assign w_next = (r_state == '0) ? ONE : {r_state[WIDTH-2:0], w_fb};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= RST_VAL;
      else     r_state <= w_next;
   end

   assign out = r_state;

endmodule

// File: tb/tb_lfsr_rng.sv
// Directed bench for lfsr_rng: reset, first steps, mid-run reset, full
// period coverage, lock-up recovery, and WIDTH=4 / WIDTH=32 corners.
module tb_lfsr_rng;

   logic        clk = 1'b0;
   logic        clk_en = 1'b0;
   logic        rst, rst4, rst32;
   logic [15:0] out;
   logic [3:0]  out4;
   logic [31:0] out32;

   int checks = 0;
   int errors = 0;

   always #5 if (clk_en) clk = ~clk;

   lfsr_rng dut (.clk(clk), .rst(rst), .out(out));
   lfsr_rng #(.WIDTH(4), .SEED(32'h0)) u4 (.clk(clk), .rst(rst4), .out(out4));
   lfsr_rng #(.WIDTH(32)) u32 (.clk(clk), .rst(rst32), .out(out32));

   typedef struct {
      logic        rst_in;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[10];
   bit   seen[65536];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref32(input logic [31:0] s);
      return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
   endfunction

   initial begin
      vecs[0] = '{1'b1, 16'hACE1};
      vecs[1] = '{1'b1, 16'hACE1};
      vecs[2] = '{1'b0, 16'h59C3};
      vecs[3] = '{1'b0, 16'hB386};
      vecs[4] = '{1'b0, 16'h670C};
      vecs[5] = '{1'b0, 16'hCE18};
      vecs[6] = '{1'b0, 16'h9C31};
      vecs[7] = '{1'b0, 16'h3862};
      vecs[8] = '{1'b1, 16'hACE1};
      vecs[9] = '{1'b0, 16'h59C3};

      // Reset with no clock running: output must settle asynchronously.
      rst = 1'b0; rst4 = 1'b1; rst32 = 1'b1;
      #2 rst = 1'b1;
      #1 check("reset_no_clock", {16'h0, out}, 32'hACE1);
      check("w4_reset", {28'h0, out4}, 32'h1);
      check("w32_reset", out32, 32'h0000_ACE1);

      clk_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         rst = vecs[i].rst_in;
         @(posedge clk);
         #1 check($sformatf("vec%0d", i), {16'h0, out}, {16'h0, vecs[i].exp});
      end

      // Mid-sequence asynchronous reset.
      repeat (100) @(posedge clk);
      #3 rst = 1'b1;
      #1 check("mid_reset_async", {16'h0, out}, 32'hACE1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1 check("mid_step1", {16'h0, out}, 32'h59C3);
      @(posedge clk); #1 check("mid_step2", {16'h0, out}, 32'hB386);
      @(posedge clk); #1 check("mid_step3", {16'h0, out}, 32'h670C);

      // Full period and coverage.
      begin
         int zeros, dups, early, distinct;
         zeros = 0; dups = 0; early = 0; distinct = 0;
         @(negedge clk); rst = 1'b1;
         @(negedge clk); rst = 1'b0;
         for (int s = 1; s <= 65535; s++) begin
            @(posedge clk);
            #1;
            if (out == 16'h0) zeros++;
            if (seen[out]) dups++;
            else begin seen[out] = 1'b1; distinct++; end
            if (s < 65535 && out == 16'hACE1) early++;
         end
         check("period_return", {16'h0, out}, 32'hACE1);
         check("period_early_return", early, 0);
         check("period_zero_seen", zeros, 0);
         check("period_duplicates", dups, 0);
         check("period_distinct", distinct, 65535);
      end

      // WIDTH=4, SEED=0: reset value 1, period 15.
      begin
         int early4, zeros4;
         early4 = 0; zeros4 = 0;
         @(negedge clk); rst4 = 1'b0;
         for (int s = 1; s <= 15; s++) begin
            @(posedge clk);
            #1;
            if (out4 == 4'h0) zeros4++;
            if (s < 15 && out4 == 4'h1) early4++;
         end
         check("w4_period_return", {28'h0, out4}, 32'h1);
         check("w4_early_or_zero", early4 + zeros4, 0);
      end

      // WIDTH=32 against an independent tap model.
      begin
         logic [31:0] m;
         int mism;
         m = 32'h0000_ACE1; mism = 0;
         @(negedge clk); rst32 = 1'b0;
         for (int s = 1; s <= 1000; s++) begin
            @(posedge clk);
            #1;
            m = ref32(m);
            if (out32 !== m) mism++;
         end
         check("w32_model_mismatches", mism, 0);
         check("w32_step1000", out32, m);
      end

      // Lock-up recovery from a forced all-zero state.
      @(negedge clk);
      force dut.r_state = 16'h0;
      #1 release dut.r_state;
      #1 check("lockup_forced", {16'h0, out}, 32'h0);
      @(posedge clk); #1 check("lockup_step1", {16'h0, out}, 32'h0001);
      @(posedge clk); #1 check("lockup_step2", {16'h0, out}, 32'h0002);
      @(posedge clk); #1 check("lockup_step3", {16'h0, out}, 32'h0004);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
